// File: rtl/mc_ctrlunit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory req/ack handshake.
// Optional MUL support (opcode F, multi-cycle EXEC) is built when MC_CTRL_MUL_EN is defined.
module mc_ctrlunit #(
    parameter int OPW        = 4,
    parameter int ALUCW      = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   op,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             jump,
    output logic             branch,
    output logic [ALUCW-1:0] alu_c,
    output logic             alusrcb,
    output logic             reg_wr,
    output logic             mem_to_reg,
    output logic             reg_des,
    output logic             wr_flag,
    output logic             illegal_op
);

    // state  | meaning
    // FETCH  | instruction request held until mem_ack, then load IR / bump PC
    // DECODE | opcode sampled into decode registers; illegal opcodes abort here
    // EXEC   | ALU cycle(s); jumps and branches resolve and finish here
    // MEM    | data request for LW/SW held until mem_ack
    // WB     | single-cycle register / flag write
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_LW  = 4'hB;
    localparam logic [3:0] OP_SW  = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD;
    localparam logic [3:0] OP_BNE = 4'hE;
    localparam logic [3:0] OP_MUL = 4'hF;

    if (MUL_CYCLES < 1 || OPW < 4) begin : g_param_check
        $error("mc_ctrlunit: MUL_CYCLES must be >= 1 and OPW >= 4");
    end

    state_t state, state_nx;
    logic   run;
    logic   upper_ok;
    logic   exec_done;

    logic [3:0]       op_lo;
    logic [ALUCW-1:0] d_alu_c;
    logic             d_srcb, d_rd, d_m2r, d_wf, d_legal;

    logic [3:0]       op_q;
    logic [ALUCW-1:0] alu_c_q;
    logic             srcb_q, rd_q, m2r_q, wf_q;

    assign op_lo = op[3:0];

    if (OPW > 4) begin : g_op_hi
        assign upper_ok = ~|op[OPW-1:4];
    end else begin : g_op_lo
        assign upper_ok = 1'b1;
    end

    always_comb begin
        d_alu_c = '0;
        d_srcb  = 1'b0;
        d_rd    = 1'b0;
        d_m2r   = 1'b0;
        d_wf    = 1'b0;
        d_legal = upper_ok;
        case (op_lo)
            4'h0: begin d_alu_c = ALUCW'(0); d_rd = 1'b1; end
            4'h1: begin d_alu_c = ALUCW'(1); d_rd = 1'b1; end
            4'h2: begin d_alu_c = ALUCW'(2); d_rd = 1'b1; d_wf = 1'b1; end
            4'h3: begin d_alu_c = ALUCW'(3); d_rd = 1'b1; d_wf = 1'b1; end
            4'h4: begin d_alu_c = ALUCW'(6); d_rd = 1'b1; end
            4'h5: begin d_alu_c = ALUCW'(5); d_rd = 1'b1; d_wf = 1'b1; end
            4'h6: begin d_alu_c = ALUCW'(4); d_rd = 1'b1; d_wf = 1'b1; end
            4'h7: d_alu_c = ALUCW'(7);
            4'h8: begin d_alu_c = ALUCW'(0); d_srcb = 1'b1; end
            4'h9: begin d_alu_c = ALUCW'(1); d_srcb = 1'b1; end
            4'hA: begin d_alu_c = ALUCW'(2); d_srcb = 1'b1; d_wf = 1'b1; end
            4'hB: begin d_alu_c = ALUCW'(2); d_srcb = 1'b1; d_m2r = 1'b1; end
            4'hC: begin d_alu_c = ALUCW'(2); d_srcb = 1'b1; end
            4'hD: d_alu_c = ALUCW'(3);
            4'hE: d_alu_c = ALUCW'(3);
            default: begin
`ifdef MC_CTRL_MUL_EN
                d_alu_c = ALUCW'(8);
                d_rd    = 1'b1;
                d_wf    = 1'b1;
`else
                d_legal = 1'b0;
`endif
            end
        endcase
    end

    // run stays low for the first clock after reset so outputs only wake up on a clean edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            alu_c_q <= '0;
            srcb_q  <= 1'b0;
            rd_q    <= 1'b0;
            m2r_q   <= 1'b0;
            wf_q    <= 1'b0;
        end else if (state == S_DECODE) begin
            op_q    <= op_lo;
            alu_c_q <= d_alu_c;
            srcb_q  <= d_srcb;
            rd_q    <= d_rd;
            m2r_q   <= d_m2r;
            wf_q    <= d_wf;
        end
    end

`ifdef MC_CTRL_MUL_EN
    localparam int CW = $clog2(MUL_CYCLES) + 1;
    logic [CW-1:0] mul_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= '0;
        end else if (state == S_DECODE) begin
            mul_cnt <= CW'(MUL_CYCLES - 1);
        end else if (state == S_EXEC && mul_cnt != '0) begin
            mul_cnt <= mul_cnt - CW'(1);
        end
    end

    assign exec_done = (op_q != OP_MUL) || (mul_cnt == '0);
`else
    assign exec_done = 1'b1;
`endif

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_c      = '0;
        alusrcb    = 1'b0;
        reg_wr     = 1'b0;
        mem_to_reg = 1'b0;
        reg_des    = 1'b0;
        wr_flag    = 1'b0;
        illegal_op = 1'b0;
        if (run) begin
            if (state == S_EXEC || state == S_MEM || state == S_WB) begin
                alu_c      = alu_c_q;
                alusrcb    = srcb_q;
                reg_des    = rd_q;
                mem_to_reg = m2r_q;
            end
            unique case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_load  = 1'b1;
                        pc_inc   = 1'b1;
                        state_nx = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!d_legal) begin
                        illegal_op = 1'b1;
                        state_nx   = S_FETCH;
                    end else begin
                        alu_c      = d_alu_c;
                        alusrcb    = d_srcb;
                        reg_des    = d_rd;
                        mem_to_reg = d_m2r;
                        state_nx   = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        case (op_q)
                            OP_JMP: begin
                                jump     = 1'b1;
                                state_nx = S_FETCH;
                            end
                            OP_BEQ: begin
                                branch   = zero;
                                state_nx = S_FETCH;
                            end
                            OP_BNE: begin
                                branch   = ~zero;
                                state_nx = S_FETCH;
                            end
                            OP_LW, OP_SW: state_nx = S_MEM;
                            default:      state_nx = S_WB;
                        endcase
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_wr  = (op_q == OP_SW);
                    if (mem_ack) begin
                        state_nx = (op_q == OP_LW) ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    reg_wr   = 1'b1;
                    wr_flag  = wf_q;
                    state_nx = S_FETCH;
                end
                default: state_nx = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrlunit.sv
// Directed bench for mc_ctrlunit: per-cycle output vectors compared against hand-built tables.
// A second OPW=5 instance covers out-of-range opcode bits.
module tb_mc_ctrlunit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] op = 4'h0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_wr, ir_load, pc_inc, jump, branch;
    logic [3:0] alu_c;
    logic       alusrcb, reg_wr, mem_to_reg, reg_des, wr_flag, illegal_op;

    logic [4:0] op5 = 5'h0;
    logic       ack5 = 1'b0;
    logic       mem_req5, mem_wr5, ir_load5, pc_inc5, jump5, branch5;
    logic [3:0] alu_c5;
    logic       alusrcb5, reg_wr5, mem_to_reg5, reg_des5, wr_flag5, illegal_op5;

    logic       a5_nx = 1'b0;
    logic [4:0] o5_nx = 5'h0;

    logic [15:0] outs, outs5;
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign outs  = {mem_req, mem_wr, ir_load, pc_inc, jump, branch, alu_c,
                    alusrcb, reg_wr, mem_to_reg, reg_des, wr_flag, illegal_op};
    assign outs5 = {mem_req5, mem_wr5, ir_load5, pc_inc5, jump5, branch5, alu_c5,
                    alusrcb5, reg_wr5, mem_to_reg5, reg_des5, wr_flag5, illegal_op5};

    mc_ctrlunit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_wr(mem_wr), .ir_load(ir_load), .pc_inc(pc_inc),
        .jump(jump), .branch(branch), .alu_c(alu_c), .alusrcb(alusrcb),
        .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .reg_des(reg_des),
        .wr_flag(wr_flag), .illegal_op(illegal_op)
    );

    mc_ctrlunit #(.OPW(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .op(op5), .zero(zero), .mem_ack(ack5),
        .mem_req(mem_req5), .mem_wr(mem_wr5), .ir_load(ir_load5), .pc_inc(pc_inc5),
        .jump(jump5), .branch(branch5), .alu_c(alu_c5), .alusrcb(alusrcb5),
        .reg_wr(reg_wr5), .mem_to_reg(mem_to_reg5), .reg_des(reg_des5),
        .wr_flag(wr_flag5), .illegal_op(illegal_op5)
    );

    // expected output vector; pc_inc always mirrors ir_load
    function automatic logic [15:0] e(input int req, input int wr, input int irl, input int jmp,
                                      input int br, input int ac, input int sb, input int rw,
                                      input int m2r, input int rd, input int wf, input int ill);
        return {req[0], wr[0], irl[0], irl[0], jmp[0], br[0], 4'(ac),
                sb[0], rw[0], m2r[0], rd[0], wf[0], ill[0]};
    endfunction

    task automatic step(input logic ack, input logic z, input logic [3:0] o, output logic [15:0] obs);
        @(negedge clk);
        mem_ack = ack;
        zero    = z;
        op      = o;
        ack5    = a5_nx;
        op5     = o5_nx;
        #1 obs = outs;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 4'h2, obs);
            checks++;
            if (obs !== 16'h0) $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, obs, 16'h0);
            else passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 4'h0, obs);
            checks++;
            if (obs !== e(1,0,0,0,0,0,0,0,0,0,0,0))
                $display("FAIL reset_fetch cyc%0d got=%h exp=%h", i, obs, e(1,0,0,0,0,0,0,0,0,0,0,0));
            else passes++;
        end
    endtask

    task automatic test_add();
        logic [15:0] obs;
        logic [15:0] exp [5];
        exp = '{e(1,0,1,0,0,0,0,0,0,0,0,0), e(0,0,0,0,0,2,0,0,0,1,0,0), e(0,0,0,0,0,2,0,0,0,1,0,0),
                e(0,0,0,0,0,2,0,1,0,1,1,0), e(1,0,0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            step((i < 4) ? 1'b1 : 1'b0, 1'b1, (i == 1) ? 4'h2 : 4'hF, obs);
            checks++;
            if (obs !== exp[i]) $display("FAIL add cyc%0d got=%h exp=%h", i, obs, exp[i]);
            else passes++;
        end
    endtask

    task automatic test_alu_ops();
        logic [15:0] obs, exp;
        logic [3:0] ops [9];
        int ac [9];
        int sb [9];
        int rd [9];
        int wf [9];
        ops = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
        ac  = '{0, 1, 3, 6, 5, 4, 0, 1, 2};
        sb  = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        rd  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        wf  = '{0, 0, 1, 0, 1, 1, 0, 0, 1};
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 5; i++) begin
                step(i == 0, k[0], (i == 1) ? ops[k] : ~ops[k], obs);
                case (i)
                    0:       exp = e(1,0,1,0,0,0,0,0,0,0,0,0);
                    1, 2:    exp = e(0,0,0,0,0,ac[k],sb[k],0,0,rd[k],0,0);
                    3:       exp = e(0,0,0,0,0,ac[k],sb[k],1,0,rd[k],wf[k],0);
                    default: exp = e(1,0,0,0,0,0,0,0,0,0,0,0);
                endcase
                checks++;
                if (obs !== exp) $display("FAIL alu_op%h cyc%0d got=%h exp=%h", ops[k], i, obs, exp);
                else passes++;
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [15:0] obs;
        logic [15:0] exp [9];
        logic ack [9];
        ack = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp = '{e(1,0,1,0,0,0,0,0,0,0,0,0), e(0,0,0,0,0,2,1,0,1,0,0,0), e(0,0,0,0,0,2,1,0,1,0,0,0),
                e(1,0,0,0,0,2,1,0,1,0,0,0), e(1,0,0,0,0,2,1,0,1,0,0,0), e(1,0,0,0,0,2,1,0,1,0,0,0),
                e(1,0,0,0,0,2,1,0,1,0,0,0), e(0,0,0,0,0,2,1,1,1,0,0,0), e(1,0,0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 9; i++) begin
            step(ack[i], 1'b0, (i == 1) ? 4'hB : 4'h3, obs);
            checks++;
            if (obs !== exp[i]) $display("FAIL lw cyc%0d got=%h exp=%h", i, obs, exp[i]);
            else passes++;
        end
    endtask

    task automatic test_sw();
        logic [15:0] obs;
        logic [15:0] exp [5];
        logic ack [5];
        ack = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp = '{e(1,0,1,0,0,0,0,0,0,0,0,0), e(0,0,0,0,0,2,1,0,0,0,0,0), e(0,0,0,0,0,2,1,0,0,0,0,0),
                e(1,1,0,0,0,2,1,0,0,0,0,0), e(1,0,0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            step(ack[i], 1'b0, (i == 1) ? 4'hC : 4'hB, obs);
            checks++;
            if (obs !== exp[i]) $display("FAIL sw cyc%0d got=%h exp=%h", i, obs, exp[i]);
            else passes++;
        end
    endtask

    task automatic test_branch_jump();
        logic [15:0] obs, exp;
        logic [3:0] ops [5];
        logic zx [5];
        int br [5];
        int jp [5];
        int ac [5];
        ops = '{4'hD, 4'hD, 4'hE, 4'hE, 4'h7};
        zx  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        br  = '{1, 0, 1, 0, 0};
        jp  = '{0, 0, 0, 0, 1};
        ac  = '{3, 3, 3, 3, 7};
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                step(i == 0, (i == 2) ? zx[k] : ~zx[k], (i == 1) ? ops[k] : 4'h2, obs);
                case (i)
                    0:       exp = e(1,0,1,0,0,0,0,0,0,0,0,0);
                    1:       exp = e(0,0,0,0,0,ac[k],0,0,0,0,0,0);
                    2:       exp = e(0,0,0,jp[k],br[k],ac[k],0,0,0,0,0,0);
                    default: exp = e(1,0,0,0,0,0,0,0,0,0,0,0);
                endcase
                checks++;
                if (obs !== exp) $display("FAIL br_op%h_z%0d cyc%0d got=%h exp=%h", ops[k], zx[k], i, obs, exp);
                else passes++;
            end
        end
    endtask

    task automatic test_mul();
        logic [15:0] obs;
`ifdef MC_CTRL_MUL_EN
        logic [15:0] exp [8];
        exp = '{e(1,0,1,0,0,0,0,0,0,0,0,0), e(0,0,0,0,0,8,0,0,0,1,0,0), e(0,0,0,0,0,8,0,0,0,1,0,0),
                e(0,0,0,0,0,8,0,0,0,1,0,0), e(0,0,0,0,0,8,0,0,0,1,0,0), e(0,0,0,0,0,8,0,0,0,1,0,0),
                e(0,0,0,0,0,8,0,1,0,1,1,0), e(1,0,0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 8; i++) begin
`else
        logic [15:0] exp [3];
        exp = '{e(1,0,1,0,0,0,0,0,0,0,0,0), e(0,0,0,0,0,0,0,0,0,0,0,1), e(1,0,0,0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 3; i++) begin
`endif
            step(i == 0, 1'b0, (i == 1) ? 4'hF : 4'h2, obs);
            checks++;
            if (obs !== exp[i]) $display("FAIL mul cyc%0d got=%h exp=%h", i, obs, exp[i]);
            else passes++;
        end
    endtask

    task automatic test_illegal_wide();
        logic [15:0] obs;
        logic [15:0] exp [3];
        logic [4:0] ov [3];
        logic av [3];
        exp = '{e(1,0,1,0,0,0,0,0,0,0,0,0), e(0,0,0,0,0,0,0,0,0,0,0,1), e(1,0,0,0,0,0,0,0,0,0,0,0)};
        ov  = '{5'h02, 5'h12, 5'h02};
        av  = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            a5_nx = av[i];
            o5_nx = ov[i];
            step(1'b0, 1'b0, 4'h0, obs);
            checks++;
            if (outs5 !== exp[i]) $display("FAIL opw5_illegal cyc%0d got=%h exp=%h", i, outs5, exp[i]);
            else passes++;
        end
        a5_nx = 1'b0;
        o5_nx = 5'h0;
    endtask

    task automatic test_reset_mid_sw();
        logic [15:0] obs;
        logic [15:0] exp [4];
        exp = '{e(1,0,1,0,0,0,0,0,0,0,0,0), e(0,0,0,0,0,2,1,0,0,0,0,0), e(0,0,0,0,0,2,1,0,0,0,0,0),
                e(1,1,0,0,0,2,1,0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 1'b0, (i == 1) ? 4'hC : 4'h0, obs);
            checks++;
            if (obs !== exp[i]) $display("FAIL rst_sw cyc%0d got=%h exp=%h", i, obs, exp[i]);
            else passes++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 16'h0) $display("FAIL rst_sw_async got=%h exp=%h", outs, 16'h0);
        else passes++;
        step(1'b1, 1'b0, 4'hC, obs);
        checks++;
        if (obs !== 16'h0) $display("FAIL rst_sw_hold got=%h exp=%h", obs, 16'h0);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 4'h0, obs);
        checks++;
        if (obs !== e(1,0,0,0,0,0,0,0,0,0,0,0))
            $display("FAIL rst_sw_release got=%h exp=%h", obs, e(1,0,0,0,0,0,0,0,0,0,0,0));
        else passes++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_wait();
        test_sw();
        test_branch_jump();
        test_mul();
        test_illegal_wide();
        test_reset_mid_sw();
        test_add();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
